// File: rtl/shared_dispatcher.sv
// rtl/shared_dispatcher.sv - round-robin front end for the shared vector/matrix compute engine
//
// Accepts one operation at a time from NUM_CLIENTS requesters, forwards it to
// the engine, waits for the engine done pulse (or a timeout) and returns the
// result to the client that was granted.
//
// Operand encodings (flattened, client i occupies slice i):
//   comp_type : 3 bits   (0 ADD, 1 SUB, 2 MUL, 3 DOT, 4 MATVEC)
//   vector    : 64 bits  (4 lanes x 16 bits, lane 0 in [15:0])
//   matrix    : 256 bits (16 elements x 16 bits, element 0 in [15:0])
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     per-client request handshake (ready one-hot or zero)
//   req_comp_type       per-client requested operation
//   req_vector_a/b      per-client vector operands
//   req_matrix          per-client matrix operand
//   rsp_valid/ready     per-client response handshake (valid one-hot or zero)
//   rsp_data, rsp_err   response payload and timeout flag
//   eng_comp_type       operation presented to the engine
//   eng_start           one-cycle engine start pulse
//   eng_vector_a/b      operands presented to the engine
//   eng_matrix          matrix presented to the engine
//   eng_busy            engine busy
//   eng_done            engine done (eng_result valid this cycle only)
//   eng_result          engine result
//   disp_busy           dispatcher not idle
//   op_count            successfully completed operations, wraps

module shared_dispatcher #(
    parameter int NUM_CLIENTS = 2,
    parameter int TIMEOUT     = 64,
    parameter int CNT_W       = 16,
    localparam int CT_W       = 3,
    localparam int VEC_W      = 64,
    localparam int MAT_W      = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CLIENTS-1:0]       req_valid,
    output logic [NUM_CLIENTS-1:0]       req_ready,
    input  logic [NUM_CLIENTS*CT_W-1:0]  req_comp_type,
    input  logic [NUM_CLIENTS*VEC_W-1:0] req_vector_a,
    input  logic [NUM_CLIENTS*VEC_W-1:0] req_vector_b,
    input  logic [NUM_CLIENTS*MAT_W-1:0] req_matrix,
    output logic [NUM_CLIENTS-1:0]       rsp_valid,
    input  logic [NUM_CLIENTS-1:0]       rsp_ready,
    output logic [VEC_W-1:0]             rsp_data,
    output logic                         rsp_err,
    output logic [CT_W-1:0]              eng_comp_type,
    output logic                         eng_start,
    output logic [VEC_W-1:0]             eng_vector_a,
    output logic [VEC_W-1:0]             eng_vector_b,
    output logic [MAT_W-1:0]             eng_matrix,
    input  logic                         eng_busy,
    input  logic                         eng_done,
    input  logic [VEC_W-1:0]             eng_result,
    output logic                         disp_busy,
    output logic [CNT_W-1:0]             op_count
);

    localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       grant_q;
    logic [TMR_W-1:0]       timer;

    logic                   grant_found;
    logic [IDX_W-1:0]       grant_idx;
    logic [NUM_CLIENTS-1:0] grant_new_oh;
    logic [NUM_CLIENTS-1:0] grant_q_oh;
    logic [CT_W-1:0]        sel_comp_type;
    logic [VEC_W-1:0]       sel_vector_a;
    logic [VEC_W-1:0]       sel_vector_b;
    logic [MAT_W-1:0]       sel_matrix;
    logic                   rsp_handshake;
    logic                   timer_expired;

    // Round-robin search: the client at rr_ptr has highest priority, then
    // rr_ptr+1, ... wrapping at NUM_CLIENTS (which need not be a power of two).
    always_comb begin
        int cand;
        cand        = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_CLIENTS) begin
                cand = cand - NUM_CLIENTS;
            end
            for (int j = 0; j < NUM_CLIENTS; j++) begin
                if (!grant_found && (j == cand) && req_valid[j]) begin
                    grant_found = 1'b1;
                    grant_idx   = IDX_W'(j);
                end
            end
        end
    end

    // Operand mux for the candidate grantee and one-hot forms of both the
    // candidate and the stored grant.
    always_comb begin
        sel_comp_type = '0;
        sel_vector_a  = '0;
        sel_vector_b  = '0;
        sel_matrix    = '0;
        grant_new_oh  = '0;
        grant_q_oh    = '0;
        for (int j = 0; j < NUM_CLIENTS; j++) begin
            if (grant_idx == IDX_W'(j)) begin
                sel_comp_type   = req_comp_type[j*CT_W +: CT_W];
                sel_vector_a    = req_vector_a[j*VEC_W +: VEC_W];
                sel_vector_b    = req_vector_b[j*VEC_W +: VEC_W];
                sel_matrix      = req_matrix[j*MAT_W +: MAT_W];
                grant_new_oh[j] = 1'b1;
            end
            if (grant_q == IDX_W'(j)) begin
                grant_q_oh[j] = 1'b1;
            end
        end
    end

    // Only the grantee's rsp_ready counts; other clients' ready is ignored.
    assign rsp_handshake = |(rsp_ready & grant_q_oh);
    assign timer_expired = (timer == TMR_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (grant_found) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!eng_busy) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (eng_done || timer_expired) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_handshake) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state; eng_start is suppressed while the engine is busy.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        eng_start = 1'b0;
        disp_busy = (state != S_IDLE);
        case (state)
            S_IDLE:  req_ready = grant_found ? grant_new_oh : '0;
            S_ISSUE: eng_start = !eng_busy;
            S_RESP:  rsp_valid = grant_q_oh;
            default: ;
        endcase
    end

    // Datapath registers: grant, operands, timer, response and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr        <= '0;
            grant_q       <= '0;
            timer         <= '0;
            eng_comp_type <= '0;
            eng_vector_a  <= '0;
            eng_vector_b  <= '0;
            eng_matrix    <= '0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
            op_count      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Operands are frozen here and held until the next accept.
                    if (grant_found) begin
                        grant_q       <= grant_idx;
                        eng_comp_type <= sel_comp_type;
                        eng_vector_a  <= sel_vector_a;
                        eng_vector_b  <= sel_vector_b;
                        eng_matrix    <= sel_matrix;
                    end
                end
                S_ISSUE: begin
                    if (!eng_busy) begin
                        timer <= '0;
                    end
                end
                S_WAIT: begin
                    // A done arriving on the expiry cycle still counts as success.
                    if (eng_done) begin
                        rsp_data <= eng_result;
                        rsp_err  <= 1'b0;
                        op_count <= op_count + CNT_W'(1);
                    end else if (timer_expired) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_handshake) begin
                        rr_ptr <= (grant_q == IDX_W'(NUM_CLIENTS - 1)) ? '0
                                                                       : grant_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_dispatcher.sv
// tb/tb_shared_dispatcher.sv - directed scoreboard bench for shared_dispatcher

module tb_shared_dispatcher;

    localparam int N  = 2;
    localparam int TO = 64;
    localparam int CW = 16;

    localparam logic [2:0] COMP_ADD = 3'd0;
    localparam logic [2:0] COMP_MUL = 3'd2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*3-1:0]   req_comp_type;
    logic [N*64-1:0]  req_vector_a;
    logic [N*64-1:0]  req_vector_b;
    logic [N*256-1:0] req_matrix;
    logic [N-1:0]     rsp_valid;
    logic [N-1:0]     rsp_ready;
    logic [63:0]      rsp_data;
    logic             rsp_err;
    logic [2:0]       eng_comp_type;
    logic             eng_start;
    logic [63:0]      eng_vector_a;
    logic [63:0]      eng_vector_b;
    logic [255:0]     eng_matrix;
    logic             eng_busy;
    logic             eng_done;
    logic [63:0]      eng_result;
    logic             disp_busy;
    logic [CW-1:0]    op_count;

    shared_dispatcher #(
        .NUM_CLIENTS(N),
        .TIMEOUT    (TO),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_comp_type(req_comp_type),
        .req_vector_a (req_vector_a),
        .req_vector_b (req_vector_b),
        .req_matrix   (req_matrix),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .eng_comp_type(eng_comp_type),
        .eng_start    (eng_start),
        .eng_vector_a (eng_vector_a),
        .eng_vector_b (eng_vector_b),
        .eng_matrix   (eng_matrix),
        .eng_busy     (eng_busy),
        .eng_done     (eng_done),
        .eng_result   (eng_result),
        .disp_busy    (disp_busy),
        .op_count     (op_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_count = 0;

    typedef struct {
        int          client;
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int c, input logic [2:0] ct, input logic [63:0] a,
                           input logic [63:0] b, input logic [255:0] m);
        req_comp_type[c*3 +: 3]  = ct;
        req_vector_a[c*64 +: 64] = a;
        req_vector_b[c*64 +: 64] = b;
        req_matrix[c*256 +: 256] = m;
    endtask

    task automatic check_clear(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_eng_start"}, eng_start, 0);
        chk({tag, "_eng_comp_type"}, eng_comp_type, 0);
        chk({tag, "_eng_vector_a"}, eng_vector_a, 0);
        chk({tag, "_eng_vector_b"}, eng_vector_b, 0);
        chk({tag, "_eng_matrix_any"}, |eng_matrix, 0);
        chk({tag, "_disp_busy"}, disp_busy, 0);
        chk({tag, "_op_count"}, op_count, 0);
    endtask

    task automatic do_reset();
        req_valid  = '0;
        rsp_ready  = '0;
        eng_busy   = 1'b0;
        eng_done   = 1'b0;
        rst        = 1'b1;
        tick();
        rst        = 1'b0;
        settle();
        sb.delete();
        exp_count  = 0;
    endtask

    // Called in the cycle where the request should be granted; leaves the
    // bench in the following (ISSUE) cycle.
    task automatic accept(input int c, input logic [63:0] res, input logic err, input string tag);
        exp_t e;
        settle();
        chk({tag, "_req_ready"}, req_ready, 64'(1 << c));
        e.client = c;
        e.data   = res;
        e.err    = err;
        sb.push_back(e);
        tick();
    endtask

    // Engine model: done k cycles after the observed start pulse (k<0: never).
    // Returns in the first cycle rsp_valid is seen.
    task automatic run_engine(input int k, input logic [63:0] res, input int exp_starts,
                              input int exp_lat, input string tag);
        int since;
        int starts;
        int got;
        int bad_ready;
        since     = -1;
        starts    = 0;
        got       = 0;
        bad_ready = 0;
        for (int c = 0; c < 300; c++) begin
            if (since >= 0) since++;
            if (rsp_valid != 0) begin
                got = 1;
                break;
            end
            if (req_ready != 0) bad_ready++;
            if (eng_start === 1'b1) begin
                starts++;
                if (since < 0) since = 0;
            end
            eng_done = (k >= 0) && (since == k);
            if (eng_done) eng_result = res;
            else eng_result = 64'hdead_beef_dead_beef;
            tick();
        end
        eng_done = 1'b0;
        chk({tag, "_rsp_seen"}, got, 1);
        chk({tag, "_start_pulses"}, starts, exp_starts);
        chk({tag, "_latency"}, since, exp_lat);
        chk({tag, "_no_grant_while_busy"}, bad_ready, 0);
    endtask

    // Holds rsp_ready low for the grantee for 'hold' cycles (other clients'
    // ready driven high, which must be ignored), then completes the handshake.
    task automatic handle_rsp(input int hold, input string tag);
        logic [N-1:0] v0;
        logic [63:0]  d0;
        logic         e0;
        int           unstable;
        int           stray;
        exp_t         e;
        v0       = rsp_valid;
        d0       = rsp_data;
        e0       = rsp_err;
        unstable = 0;
        stray    = 0;
        for (int i = 0; i < hold; i++) begin
            rsp_ready = ~v0;
            tick();
            if (rsp_valid !== v0 || rsp_data !== d0 || rsp_err !== e0) unstable++;
            if (req_ready != 0) stray++;
        end
        if (hold > 0) begin
            chk({tag, "_rsp_stable"}, unstable, 0);
            chk({tag, "_no_grant_in_resp"}, stray, 0);
        end
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_rsp_client"}, v0, 64'(1 << e.client));
            chk({tag, "_rsp_data"}, d0, e.data);
            chk({tag, "_rsp_err"}, e0, e.err);
        end
        rsp_ready = v0;
        tick();
        rsp_ready = '0;
        settle();
        chk({tag, "_rsp_valid_drop"}, rsp_valid, 0);
        chk({tag, "_idle_after"}, disp_busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] res;
        int          busy_starts;
        int          ghost;

        req_valid     = '0;
        rsp_ready     = '0;
        req_comp_type = '0;
        req_vector_a  = '0;
        req_vector_b  = '0;
        req_matrix    = '0;
        eng_busy      = 1'b0;
        eng_done      = 1'b0;
        eng_result    = '0;
        rst           = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
        check_clear("reset");

        // 1: single client, MUL, done 16 cycles after start
        set_req(0, COMP_MUL, 64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005,
                {16{16'h00a5}});
        set_req(1, COMP_ADD, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                {16{16'h0b0b}});
        req_valid = 2'b01;
        accept(0, 64'h0000_0000_0000_0005, 1'b0, "t1");
        req_valid = '0;
        chk("t1_eng_comp_type", eng_comp_type, COMP_MUL);
        chk("t1_eng_vector_a", eng_vector_a, 64'h0004_0003_0002_0001);
        chk("t1_eng_vector_b", eng_vector_b, 64'h0008_0007_0006_0005);
        chk("t1_eng_start", eng_start, 1);
        chk("t1_disp_busy", disp_busy, 1);
        run_engine(16, 64'h0000_0000_0000_0005, 1, 17, "t1");
        exp_count++;
        chk("t1_op_count", op_count, exp_count);
        chk("t1_operands_held", eng_vector_a, 64'h0004_0003_0002_0001);
        handle_rsp(0, "t1");

        // 2: both clients requesting continuously from reset -> 0,1,0,1
        do_reset();
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            res = 64'h0000_0000_0000_0100 + 64'(i);
            accept(i % 2, res, 1'b0, $sformatf("t2_op%0d", i));
            chk($sformatf("t2_op%0d_eng_vector_a", i), eng_vector_a,
                (i % 2 == 0) ? 64'h0004_0003_0002_0001 : 64'h1111_1111_1111_1111);
            run_engine(3, res, 1, 4, $sformatf("t2_op%0d", i));
            exp_count++;
            handle_rsp(0, $sformatf("t2_op%0d", i));
        end
        chk("t2_op_count", op_count, exp_count);

        // 3: client1 response back-pressured 10 cycles while client0 waits
        req_valid = 2'b10;
        accept(1, 64'h0000_0000_0000_0333, 1'b0, "t3");
        req_valid = 2'b11;
        run_engine(2, 64'h0000_0000_0000_0333, 1, 3, "t3");
        exp_count++;
        handle_rsp(10, "t3");
        // rr_ptr is now 0: with both valid, client0 wins (this op times out)
        accept(0, 64'h0, 1'b1, "t3_next");
        req_valid = '0;

        // 4: engine never answers -> timeout response with error
        run_engine(-1, 64'h0, 1, TO + 1, "t4");
        chk("t4_op_count_unchanged", op_count, exp_count);
        handle_rsp(0, "t4");

        // 5: engine busy for 5 cycles after accept delays the start pulse
        req_valid = 2'b10;
        accept(1, 64'h0000_0000_0000_0555, 1'b0, "t5");
        req_valid   = '0;
        eng_busy    = 1'b1;
        busy_starts = 0;
        for (int i = 0; i < 5; i++) begin
            settle();
            if (eng_start !== 1'b0) busy_starts++;
            tick();
        end
        chk("t5_no_start_while_busy", busy_starts, 0);
        eng_busy = 1'b0;
        settle();
        chk("t5_start_after_busy", eng_start, 1);
        run_engine(4, 64'h0000_0000_0000_0555, 1, 5, "t5");
        exp_count++;
        handle_rsp(0, "t5");
        chk("t5_op_count", op_count, exp_count);

        // 6: reset in the middle of WAIT
        req_valid = 2'b10;
        accept(1, 64'h0, 1'b0, "t6");
        req_valid = '0;
        for (int i = 0; i < 5; i++) tick();
        chk("t6_busy_before_reset", disp_busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check_clear("t6_after_reset");
        sb.delete();
        exp_count = 0;
        eng_done   = 1'b1;
        eng_result = 64'h0000_0000_0000_0666;
        tick();
        eng_done = 1'b0;
        ghost = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid != 0 || disp_busy !== 1'b0 || op_count != 0) ghost++;
            tick();
        end
        chk("t6_no_ghost_response", ghost, 0);
        req_valid = 2'b11;
        accept(0, 64'h0000_0000_0000_0777, 1'b0, "t6_next");
        req_valid = '0;
        run_engine(1, 64'h0000_0000_0000_0777, 1, 2, "t6_next");
        exp_count++;
        handle_rsp(0, "t6_next");
        chk("t6_op_count", op_count, exp_count);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shared_dispatcher.md
Name: shared_dispatcher

Overview:
Initiator/front end for the shared vector/matrix compute unit. Accepts operation requests from NUM_CLIENTS requesters and arbitrates round-robin. Drives the engine's start/comp_type/operand inputs, waits for the engine's done pulse and captures the result. Returns the result to the granted client over a valid/ready response channel, with a timeout guard.

Parameters:
NUM_CLIENTS, 2, number of requesting clients (2..8).
TIMEOUT, 64, max cycles in WAIT before aborting with error (>=20).
CNT_W, 16, width of completed-operation counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_CLIENTS  per-client request valid
req_ready  out  NUM_CLIENTS  per-client request accept (one-hot or zero)
req_comp_type  in  NUM_CLIENTS x computation_type_t  requested op
req_vector_a  in  NUM_CLIENTS x vector_data_t  operand A
req_vector_b  in  NUM_CLIENTS x vector_data_t  operand B
req_matrix  in  NUM_CLIENTS x matrix_data_t  matrix operand
rsp_valid  out  NUM_CLIENTS  per-client response valid (one-hot or zero)
rsp_ready  in  NUM_CLIENTS  per-client response accept
rsp_data  out  vector_data_t  result, qualified by rsp_valid
rsp_err  out  1  timeout flag, qualified by rsp_valid
eng_comp_type  out  computation_type_t  to engine
eng_start  out  1  engine start pulse
eng_vector_a / eng_vector_b  out  vector_data_t  latched operands
eng_matrix  out  matrix_data_t  latched matrix
eng_busy  in  1  engine busy
eng_done  in  1  engine done (result valid this cycle only)
eng_result  in  vector_data_t  engine result
disp_busy  out  1  high in any state other than IDLE
op_count  out  CNT_W  completed ops without error, wraps

Behaviour:
- Reset (clk edge with rst=1): state IDLE, rr_ptr=0, all outputs 0 (req_ready, rsp_valid, rsp_data, rsp_err, eng_*, disp_busy, op_count). Reset in any state aborts the op with no response; the engine is not notified.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: grant g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_CLIENTS. req_ready[g]=1 combinationally in IDLE only. On that cycle, latch comp_type/vector_a/vector_b/matrix of client g into eng_* registers and store g. Next state ISSUE. No valid: stay.
- Requesters hold valid and operands stable until ready. Only the grant sees ready.
- ISSUE: eng_start=1 for exactly one cycle when eng_busy=0, then WAIT. If eng_busy=1, hold in ISSUE with eng_start=0. Timeout counter does not run in ISSUE.
- WAIT: timer cleared on entry and incremented each cycle. eng_done=1 captures eng_result into rsp_data with rsp_err=0, op_count+1, next RESP. Else, when the timer reaches TIMEOUT-1, rsp_data=0, rsp_err=1, op_count unchanged, next RESP. done in the same cycle as expiry: done wins.
- eng_done outside WAIT is ignored.
- eng_* operand registers stay stable from the accept cycle until return to IDLE.
- RESP: rsp_valid[g]=1, rsp_data/rsp_err held stable until rsp_ready[g]=1. On that cycle: rsp_valid deasserts next cycle, rr_ptr=(g+1) mod NUM_CLIENTS, next IDLE. rsp_ready of other clients is ignored.
- Fairness: a client continuously requesting is granted at most once before every other requesting client is served.
- Minimum latency with engine idle: accept at T, eng_start at T+1, done at T+1+k gives rsp_valid from T+2+k. Earliest next accept is the cycle after the rsp handshake.
- op_count wraps from all-ones to 0.

Test Plan:
1. Client0 only: req_valid[0] with comp_type=COMP_MUL; engine model asserts done 16 cycles after start, result data[0]=16'h0005 -> req_ready[0] one cycle; eng_start exactly one pulse at T+1; rsp_valid[0] at T+18 with rsp_data.data[0]=16'h0005, rsp_err=0; op_count=1.
2. Both clients valid continuously from reset -> grant order 0,1,0,1 over four ops; req_ready never asserted to two clients at once; each rsp goes only to its grantee.
3. rsp_ready[1] held low 10 cycles in RESP -> rsp_valid[1] and rsp_data stable for all 10 cycles; no new grant until the handshake; then rr_ptr=0.
4. Engine never asserts done -> rsp_valid with rsp_err=1, rsp_data=0 exactly TIMEOUT=64 cycles after entering WAIT; op_count unchanged.
5. eng_busy forced high 5 cycles after accept -> eng_start low during those cycles, pulses the cycle after eng_busy falls.
6. rst=1 for one cycle mid-WAIT -> next cycle all outputs 0, disp_busy=0; a later engine done produces no response; next request served normally from client0.
